// File: rtl/alu_seq_pkg.sv
// Shared state encoding, ALU op codes and decode constants for the ALU sequencer.
// Macro ALU_SEQ_STEP_EN adds the WAIT_STEP single-step state.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED
`ifdef ALU_SEQ_STEP_EN
    , S_WAIT_STEP
`endif
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOT  = 4'b0101;
  localparam logic [3:0] ALU_SHL  = 4'b0110;
  localparam logic [3:0] ALU_SHR  = 4'b0111;
  localparam logic [3:0] ALU_ROL  = 4'b1000;
  localparam logic [3:0] ALU_ROR  = 4'b1001;
  localparam logic [3:0] ALU_INC  = 4'b1010;
  localparam logic [3:0] ALU_DEC  = 4'b1011;
  localparam logic [3:0] ALU_HALT = 4'b1100;

  localparam logic [3:0] HALT_CODE   = ALU_HALT;
  localparam logic [3:0] ILLEGAL_MIN = 4'b1101;

  function automatic logic is_illegal(input logic [3:0] code);
    return code >= ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/alu_seq_pc.sv
// Program counter (wrapping) and retired-instruction counter (saturating).
module alu_seq_pc #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_inc,
  input  logic             cnt_inc,
  output logic [PC_W-1:0]  pc,
  output logic [CNT_W-1:0] instr_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      instr_cnt <= '0;
    end else begin
      if (pc_inc)
        pc <= pc + PC_W'(1);
      // Counter sticks at all-ones rather than rolling over.
      if (cnt_inc && (instr_cnt != {CNT_W{1'b1}}))
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the ALU-op decoder and register file.
// Macro ALU_SEQ_STEP_EN adds the step input and holds after each writeback until step=1.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int         PC_W      = 8,
  parameter int         CNT_W     = 16,
  parameter logic [3:0] HALT_CODE = alu_seq_pkg::HALT_CODE
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic             start,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  output logic             mem_req,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       alu_code,
  output logic             alu_en,
  output logic [3:0]       rf_addr,
  output logic             rf_we,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t     state, nxt;
  logic [7:0] ir;
  logic       pc_inc, cnt_inc;
  logic [3:0] ir_code;

  assign ir_code = ir[7:4];

  always_comb begin
    nxt     = state;
    pc_inc  = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  if (mem_ack) nxt = S_DECODE;
      S_DECODE: begin
        if (ir_code == HALT_CODE) begin
          nxt     = S_HALTED;
          cnt_inc = 1'b1;
        end else if (is_illegal(ir_code)) begin
          nxt    = S_FETCH;
          pc_inc = 1'b1;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC:   nxt = S_WB;
      S_WB: begin
        pc_inc  = 1'b1;
        cnt_inc = 1'b1;
`ifdef ALU_SEQ_STEP_EN
        nxt = S_WAIT_STEP;
`else
        nxt = S_FETCH;
`endif
      end
`ifdef ALU_SEQ_STEP_EN
      S_WAIT_STEP: if (step) nxt = S_FETCH;
`endif
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      alu_code <= '0;
      rf_addr  <= '0;
      illegal  <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_FETCH && mem_ack)
        ir <= mem_data;
      // alu_code/rf_addr hold from DECODE through WB for the downstream decoder.
      if (state == S_DECODE) begin
        alu_code <= ir_code;
        rf_addr  <= ir[3:0];
        if (ir_code != HALT_CODE && is_illegal(ir_code))
          illegal <= 1'b1;
      end
    end
  end

  alu_seq_pc #(
    .PC_W  (PC_W),
    .CNT_W (CNT_W)
  ) u_pc (
    .clk       (clk),
    .rst       (rst),
    .pc_inc    (pc_inc),
    .cnt_inc   (cnt_inc),
    .pc        (pc),
    .instr_cnt (instr_cnt)
  );

  assign mem_req = (state == S_FETCH);
  assign alu_en  = (state == S_EXEC);
  assign rf_we   = (state == S_WB);
  assign halted  = (state == S_HALTED);
  assign busy    = (state != S_IDLE) && (state != S_HALTED);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized per-instruction checks of alu_seq_ctrl against an instruction-level reference model.
module tb_alu_seq_ctrl;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, mem_ack;
  logic [7:0]       mem_data;
  logic             mem_req, alu_en, rf_we, busy, halted, illegal;
  logic [PC_W-1:0]  pc;
  logic [3:0]       alu_code, rf_addr;
  logic [CNT_W-1:0] instr_cnt;
`ifdef ALU_SEQ_STEP_EN
  logic             step;
`endif

  alu_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef ALU_SEQ_STEP_EN
    .step      (step),
`endif
    .start     (start),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .mem_req   (mem_req),
    .pc        (pc),
    .alu_code  (alu_code),
    .alu_en    (alu_en),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: architectural state at instruction granularity.
  logic [7:0]  mem [256];
  logic [7:0]  mpc;
  logic [15:0] mcnt;
  logic        millegal;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {mem_req, alu_en, rf_we, busy, halted, illegal}, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_cnt"}, instr_cnt, 0);
    chk({tag, "_code_addr"}, {alu_code, rf_addr}, 0);
  endtask

  // Runs one instruction from the current fetch, with dly wait cycles before ack.
  task automatic run_instr(input int dly);
    logic [7:0] instr;
    logic [3:0] code;
    int w = 0;
    while (mem_req !== 1'b1 && w < 8) begin
      tick();
      w++;
    end
    chk("fetch_req", mem_req, 1);
    chk("fetch_pc", pc, mpc);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", mem_req, 1);
    end
    instr    = mem[mpc];
    code     = instr[7:4];
    mem_ack  = 1'b1;
    mem_data = instr;
    tick();
    mem_ack  = 1'b0;
    mem_data = 8'($urandom);
    chk("decode_quiet", {alu_en, rf_we, mem_req, busy}, 4'b0001);
    if (code == 4'hC) begin
      tick();
      retire();
      chk("halt_state", {halted, busy}, 2'b10);
      chk("halt_cnt", instr_cnt, mcnt);
      chk("halt_pc", pc, mpc);
      for (int i = 0; i < 20; i++) begin
        mem_ack = 1'($urandom);
        tick();
        chk("halt_idle", {mem_req, halted, busy, alu_en, rf_we}, 5'b01000);
      end
      mem_ack = 1'b0;
    end else if (code >= 4'hD) begin
      tick();
      millegal = 1'b1;
      mpc      = mpc + 8'd1;
      chk("ill_flag", illegal, 1);
      chk("ill_refetch", {mem_req, alu_en, rf_we}, 3'b100);
      chk("ill_pc", pc, mpc);
      chk("ill_cnt", instr_cnt, mcnt);
    end else begin
      mem_ack = 1'($urandom);
      tick();
      chk("exec", {alu_en, rf_we, mem_req}, 3'b100);
      chk("exec_code", alu_code, code);
      mem_ack = 1'($urandom);
      tick();
      chk("wb", {alu_en, rf_we, mem_req}, 3'b010);
      chk("wb_addr", rf_addr, instr[3:0]);
      chk("wb_code", alu_code, code);
      mem_ack = 1'b0;
      tick();
      mpc = mpc + 8'd1;
      retire();
      chk("post_pc", pc, mpc);
      chk("post_cnt", instr_cnt, mcnt);
      chk("post_illegal", illegal, millegal);
`ifdef ALU_SEQ_STEP_EN
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        chk("wait_step", {mem_req, busy, rf_we}, 3'b010);
        tick();
      end
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = 8'h00;
`ifdef ALU_SEQ_STEP_EN
    step     = 1'b0;
`endif
    mpc      = 8'h00;
    mcnt     = 16'h0000;
    millegal = 1'b0;
    #1;
    check_reset_outputs("reset");

    mem[0] = 8'h25;
    mem[1] = {4'($urandom_range(0, 11)), 4'($urandom)};
    mem[2] = 8'hE3;
    mem[3] = 8'h7A;
    for (int k = 4; k < 256; k++) begin
      mem[k] = 8'($urandom);
      if (mem[k][7:4] == 4'hC) mem[k][7:4] = 4'h0;
    end

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_wait", {busy, mem_req}, 2'b00);
    start = 1'b1;
    tick();
    chk("start_fetch", {mem_req, busy}, 2'b11);
    start = 1'b0;

    run_instr(0);
    run_instr(3);
    run_instr(0);
    run_instr(0);
    chk("illegal_sticky", illegal, 1);
    for (int k = 4; k < 256; k++)
      run_instr(int'($urandom_range(0, 3)));
    chk("pc_wrap", pc, 0);

    mem[0] = 8'hC0;
    run_instr(0);

    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b1;
    mpc = 8'h00; mcnt = 16'h0000; millegal = 1'b0;
    tick();
    chk("restart_fetch", mem_req, 1);
    mem_ack  = 1'b1;
    mem_data = 8'h47;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("pre_abort_exec", alu_en, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("abort_no_we", {rf_we, pc}, 0);
    end
    rst = 1'b0;
    tick();
    mem[0] = 8'h47;
    run_instr(1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
